// File: rtl/seg_scan_capture.sv
// Recovers the hex value shown on each digit of a multiplexed 4-digit seven-segment display.
// Optional macro STALE_TIMEOUT_EN adds per-digit staleness timers that drop digit_vld.
module seg_scan_capture #(
    parameter int SETTLE_CYCLES = 16,
    parameter int STALE_WIDTH   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg,
    input  logic [3:0] an,
    output logic [3:0] digit_a,
    output logic [3:0] digit_b,
    output logic [3:0] digit_c,
    output logic [3:0] digit_d,
    output logic [3:0] digit_vld,
    output logic [3:0] dec_err,
    output logic       conflict,
    output logic       upd_stb
);

    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_LOCKED, S_CONFLICT} state_t;

    localparam logic [7:0] L_SETTLE  = 8'(SETTLE_CYCLES);
    localparam logic [7:0] L_LOCK_AT = 8'(SETTLE_CYCLES - 1);

    // Returns {legal, value}; anything outside the sixteen glyphs is illegal.
    function automatic logic [4:0] f_decode(input logic [6:0] s);
        logic [4:0] r;
        case (s)
            7'h40:   r = 5'h10;
            7'h79:   r = 5'h11;
            7'h24:   r = 5'h12;
            7'h30:   r = 5'h13;
            7'h19:   r = 5'h14;
            7'h12:   r = 5'h15;
            7'h02:   r = 5'h16;
            7'h78:   r = 5'h17;
            7'h00:   r = 5'h18;
            7'h10:   r = 5'h19;
            7'h08:   r = 5'h1A;
            7'h03:   r = 5'h1B;
            7'h46:   r = 5'h1C;
            7'h21:   r = 5'h1D;
            7'h06:   r = 5'h1E;
            7'h0E:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    logic [6:0]  r_seg_p0, r_seg_p1;
    logic [3:0]  r_an_p0, r_an_p1;
    logic [10:0] r_prev;
    logic [7:0]  r_cnt;
    state_t      r_state;
    logic [3:0]  r_digit [4];
    logic [3:0]  r_vld;
    logic [3:0]  r_err;
    logic        r_conflict;
    logic        r_stb;

    logic [10:0] w_cur;
    logic [3:0]  w_low;
    logic [2:0]  w_low_cnt;
    logic [1:0]  w_idx;
    logic        w_changed;
    logic [7:0]  w_cnt_nxt;
    state_t      w_state_nxt;
    logic        w_capture;
    logic [4:0]  w_dec;

    // Stage p0/p1: two-flop synchronizers, then change detection against the previous sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg_p0 <= '0;
            r_seg_p1 <= '0;
            r_an_p0  <= '0;
            r_an_p1  <= '0;
            r_prev   <= '0;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
        end else begin
            r_seg_p0 <= seg;
            r_seg_p1 <= r_seg_p0;
            r_an_p0  <= an;
            r_an_p1  <= r_an_p0;
            r_prev   <= w_cur;
            r_cnt    <= w_cnt_nxt;
            r_state  <= w_state_nxt;
        end
    end

    always_comb begin
        w_cur       = {r_an_p1, r_seg_p1};
        w_low       = ~r_an_p1;
        w_low_cnt   = {2'b00, w_low[0]} + {2'b00, w_low[1]} + {2'b00, w_low[2]} + {2'b00, w_low[3]};
        w_idx       = 2'd0;
        w_changed   = (w_cur != r_prev);
        w_cnt_nxt   = r_cnt;
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_dec       = f_decode(r_seg_p1);

        if (w_low[3])      w_idx = 2'd3;
        else if (w_low[2]) w_idx = 2'd2;
        else if (w_low[1]) w_idx = 2'd1;

        if (w_changed)               w_cnt_nxt = '0;
        else if (r_cnt != L_SETTLE)  w_cnt_nxt = r_cnt + 8'd1;

        // The capture fires on the edge where the counter would reach SETTLE_CYCLES-1,
        // which lands SETTLE_CYCLES edges after the first stable synchronized sample.
        if (w_changed) begin
            if (w_low_cnt == 3'd0)      w_state_nxt = S_IDLE;
            else if (w_low_cnt == 3'd1) w_state_nxt = S_SETTLE;
            else                        w_state_nxt = S_CONFLICT;
        end else if (r_state == S_SETTLE && w_cnt_nxt == L_LOCK_AT) begin
            w_state_nxt = S_LOCKED;
            w_capture   = 1'b1;
        end
    end

`ifdef STALE_TIMEOUT_EN
    logic [STALE_WIDTH-1:0] r_stale [4];
`else
    logic w_unused_stale;
    assign w_unused_stale = ^STALE_WIDTH;
`endif

    // Stage p2: capture registers and flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                r_digit[i] <= '0;
`ifdef STALE_TIMEOUT_EN
                r_stale[i] <= '0;
`endif
            end
            r_vld      <= '0;
            r_err      <= '0;
            r_conflict <= 1'b0;
            r_stb      <= 1'b0;
        end else begin
            r_stb      <= w_capture;
            r_conflict <= (w_state_nxt == S_CONFLICT) && (w_cnt_nxt >= L_LOCK_AT);
            for (int i = 0; i < 4; i++) begin
                if (w_capture && (w_idx == 2'(i))) begin
                    if (w_dec[4]) begin
                        r_digit[i] <= w_dec[3:0];
                        r_err[i]   <= 1'b0;
                        r_vld[i]   <= 1'b1;
                    end else begin
                        r_err[i]   <= 1'b1;
                        r_vld[i]   <= 1'b0;
                    end
`ifdef STALE_TIMEOUT_EN
                    r_stale[i] <= '0;
                end else begin
                    r_stale[i] <= r_stale[i] + STALE_WIDTH'(1);
                    if (r_stale[i] == '1) r_vld[i] <= 1'b0;
`endif
                end
            end
        end
    end

    assign digit_a   = r_digit[0];
    assign digit_b   = r_digit[1];
    assign digit_c   = r_digit[2];
    assign digit_d   = r_digit[3];
    assign digit_vld = r_vld;
    assign dec_err   = r_err;
    assign conflict  = r_conflict;
    assign upd_stb   = r_stb;

endmodule

// File: doc/seg_scan_capture.md
# seg_scan_capture

- Sequential monitor for the four-digit seven-segment display interface: watches the multiplexed segment/anode lines and recovers the hex value shown on each digit.
- Sits on the board-side seg/an nets alongside the display driver; used for loopback self-check and as the hardware reference for display verification.
- Synchronizes the lines, waits until each digit pattern is stable, and decodes the pattern back to a 4-bit value.
- Raises per-digit valid and error flags.

## Interface

Parameters:
- SETTLE_CYCLES, 16, consecutive identical synchronized samples required before a pattern is accepted (2..255).
- STALE_WIDTH, 20, width of per-digit staleness counter; a digit goes stale after 2^STALE_WIDTH cycles without refresh.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous assert, active-low; one clock, no other clock domain.
- seg  input  7  segment lines, active-low; seg[6:0] = g,f,e,d,c,b,a; asynchronous to clk.
- an  input  4  anode lines, active-low; an[0]=digit A … an[3]=digit D; asynchronous to clk.
- digit_a, digit_b, digit_c, digit_d  output  4 each  last decoded value per digit.
- digit_vld  output  4  bit i set when digit i holds a fresh decoded value.
- dec_err  output  4  bit i set when last accepted pattern on digit i was not a legal hex glyph.
- conflict  output  1  more than one anode low in the current stable sample.
- upd_stb  output  1  one-cycle pulse on each accepted capture.

## Operation

Input path:
- seg and an each pass through a 2-flop synchronizer.
- All logic below uses the synchronized values.

Stability counter:
- The counter resets to 0 whenever the synchronized {an,seg} differs from the previous cycle.
- Otherwise it increments and saturates at SETTLE_CYCLES.

State machine states:
- IDLE: all anodes high.
- SETTLE: exactly one anode low, counter < SETTLE_CYCLES-1.
- LOCKED: pattern accepted.
- CONFLICT: two or more anodes low.

Transitions:
- Any change of synchronized {an,seg}: go to IDLE, SETTLE or CONFLICT according to the anode count.
- SETTLE → LOCKED when the counter reaches SETTLE_CYCLES-1.

On SETTLE → LOCKED, for active digit i:
- Decode seg. Legal glyphs, hex of seg[6:0]: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Legal glyph: digit_i ← value, dec_err[i] ← 0, digit_vld[i] ← 1.
- Illegal glyph: digit_i holds its previous value, dec_err[i] ← 1, digit_vld[i] ← 0.
- upd_stb pulses in both cases.

While LOCKED:
- No further captures and no further upd_stb until the pattern changes.
- A re-scan of the same digit after a change re-captures it.

CONFLICT:
- conflict = 1 while in CONFLICT (once stable SETTLE_CYCLES), 0 otherwise.
- No digit is updated.

IDLE:
- Blank period; no capture.
- Digit registers and flags hold.

## Timing

Reset values:
- All digit_* = 0, digit_vld = 0, dec_err = 0, conflict = 0, upd_stb = 0.
- Synchronizers, counters and staleness timers cleared; state = IDLE.

Latency:
- A pattern change at the pins is seen internally 2 cycles later.
- Capture is registered SETTLE_CYCLES cycles after the first stable internal sample.
- Pin-to-output latency is therefore 2+SETTLE_CYCLES cycles.
- upd_stb is asserted in the same cycle the new digit_*/flags appear.

Boundary conditions:
- A pattern that changes before the counter reaches SETTLE_CYCLES-1 is discarded; nothing updates.
- If a staleness expiry and a capture hit the same digit in the same cycle, the capture wins.
- Reset asserted mid-SETTLE: outputs return to reset values immediately, asynchronously.
- After reset deasserts, capture restarts from the synchronizer stage.
- Segment glitches shorter than SETTLE_CYCLES produce no output change.

## Configuration

STALE_TIMEOUT_EN:
- Defined: each digit has a STALE_WIDTH-bit timer, cleared on that digit's capture and incremented otherwise.
- Defined: on wrap, digit_vld[i] ← 0; the digit value and dec_err[i] hold.
- Undefined: no timers are built, and digit_vld bits clear only on reset or an illegal-glyph capture.

## Test plan

- Reset: hold rst_n low with an=4'b0000, seg=0 → all outputs 0; release → no upd_stb until a single anode is low.
- Scan: an=1110, seg=7'h24 held 20 cycles → at cycle 2+16, digit_a=2, digit_vld=0001, upd_stb one pulse only.
- Glitch: an=1101, seg=7'h19 for 10 cycles, then 7'h12 for 30 cycles → digit_b=5, exactly one upd_stb, value 4 never appears.
- Illegal glyph: digit_c=7 captured, then an=1011, seg=7'h7F stable → dec_err=0100, digit_vld[2]=0, digit_c stays 7.
- Conflict: an=1100 stable 20 cycles → conflict=1, no upd_stb; an=1111 → conflict=0, digits hold.
- STALE_TIMEOUT_EN with STALE_WIDTH=6: capture digit_d=F, then keep an=1111 → digit_vld[3] clears after 64 cycles; digit_d stays F.
